// File: rtl/dec_chain_ctrl.sv
// dec_chain_ctrl: sequencing and configuration controller for the receive decimation chain
// (CIC -> hb1 -> hb2). It decodes a requested total decimation into the CIC rate and the
// halfband bypass bits. On a reconfiguration it stops and drains the chain, then loads the
// new settings. After restart it hides the first chain output strobes from downstream.
//
// Optional build macro: DEC_CTRL_STATS_EN adds the reconfig_count and drop_count outputs.

module dec_chain_ctrl #(
   parameter int unsigned FLUSH_CYCLES   = 64,  // DRAIN length in clocks, 1..255
   parameter int unsigned SETTLE_OUTPUTS = 4    // strobes hidden after restart, 0..255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        cfg_stb,
   input  logic [7:0]  cfg_rate,
   input  logic        chain_stb,
   output logic        run_o,
   output logic [7:0]  cic_rate,
   output logic        hb1_bypass,
   output logic        hb2_bypass,
   output logic        cfg_busy,
   output logic        cfg_err,
   output logic        stb_valid
`ifdef DEC_CTRL_STATS_EN
   ,
   output logic [15:0] reconfig_count,
   output logic [15:0] drop_count
`endif
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StLoad   = 3'd1;
   localparam logic [2:0] StSettle = 3'd2;
   localparam logic [2:0] StRun    = 3'd3;
   localparam logic [2:0] StDrain  = 3'd4;

   localparam logic [7:0] FlushLast   = 8'(FLUSH_CYCLES - 1);
   localparam logic [7:0] SettleCount = 8'(SETTLE_OUTPUTS);

   logic [2:0] state_q, state_d;
   // Shared counter: drain cycles remaining in DRAIN, strobes seen in SETTLE.
   logic [7:0] cnt_q, cnt_d;
   logic       reload_q, reload_d;
   logic       load_apply;

   logic [7:0] pend_cic_q;
   logic       pend_hb1_q, pend_hb2_q;
   logic [7:0] cic_q;
   logic       hb1_q, hb2_q;
   logic       run_q, busy_q, in_run_q, err_q;

   logic [7:0] dec_cic;
   logic       dec_hb1, dec_hb2;
   logic       cfg_open, cfg_acc, cfg_rej;

   // Rate decode: strip a factor of two per active halfband.
   always_comb begin
      dec_cic = cfg_rate;
      dec_hb1 = 1'b1;
      dec_hb2 = 1'b1;
      if (cfg_rate[1:0] == 2'b00) begin
         dec_cic = {2'b00, cfg_rate[7:2]};
         dec_hb1 = 1'b0;
         dec_hb2 = 1'b0;
      end else if (cfg_rate[0] == 1'b0) begin
         dec_cic = {1'b0, cfg_rate[7:1]};
         dec_hb1 = 1'b1;
         dec_hb2 = 1'b0;
      end
   end

   // Configuration is only taken while the chain is idle or steadily running.
   always_comb begin
      cfg_open = (state_q == StIdle) || (state_q == StRun);
      cfg_acc  = cfg_stb && cfg_open && (cfg_rate != 8'd0);
      cfg_rej  = cfg_stb && !cfg_acc;
   end

   // Next-state logic for the sequencing FSM and its shared counter.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      reload_d   = reload_q;
      load_apply = 1'b0;
      case (state_q)
         StIdle: begin
            if (cfg_acc) begin
               state_d = StLoad;
            end else if (enable) begin
               state_d = StSettle;
               cnt_d   = 8'd0;
            end
         end
         StLoad: begin
            load_apply = 1'b1;
            reload_d   = 1'b0;
            if (enable) begin
               state_d = StSettle;
               cnt_d   = 8'd0;
            end else begin
               state_d = StIdle;
            end
         end
         StSettle: begin
            if (!enable) begin
               state_d  = StDrain;
               cnt_d    = FlushLast;
               reload_d = 1'b0;
            end else if (cnt_q == SettleCount) begin
               state_d = StRun;
            end else if (chain_stb) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StRun: begin
            // A config strobe wins over enable falling; LOAD then resolves enable.
            if (cfg_acc) begin
               state_d  = StDrain;
               cnt_d    = FlushLast;
               reload_d = 1'b1;
            end else if (!enable) begin
               state_d  = StDrain;
               cnt_d    = FlushLast;
               reload_d = 1'b0;
            end
         end
         StDrain: begin
            if (cnt_q == 8'd0) begin
               state_d = reload_q ? StLoad : StIdle;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d  = StIdle;
            cnt_d    = 8'd0;
            reload_d = 1'b0;
         end
      endcase
   end

   // State, pending settings, applied settings and registered output decodes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         reload_q   <= 1'b0;
         pend_cic_q <= 8'd1;
         pend_hb1_q <= 1'b1;
         pend_hb2_q <= 1'b1;
         cic_q      <= 8'd1;
         hb1_q      <= 1'b1;
         hb2_q      <= 1'b1;
         run_q      <= 1'b0;
         busy_q     <= 1'b0;
         in_run_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         // Decodes are taken from the next state so they line up with state_q.
         run_q    <= (state_d == StSettle) || (state_d == StRun);
         busy_q   <= (state_d == StDrain) || (state_d == StLoad) || (state_d == StSettle);
         in_run_q <= (state_d == StRun);
         if (cfg_acc) begin
            pend_cic_q <= dec_cic;
            pend_hb1_q <= dec_hb1;
            pend_hb2_q <= dec_hb2;
            err_q      <= 1'b0;
         end else if (cfg_rej) begin
            err_q <= 1'b1;
         end
         if (load_apply) begin
            cic_q <= pend_cic_q;
            hb1_q <= pend_hb1_q;
            hb2_q <= pend_hb2_q;
         end
      end
   end

   assign run_o      = run_q;
   assign cic_rate   = cic_q;
   assign hb1_bypass = hb1_q;
   assign hb2_bypass = hb2_q;
   assign cfg_busy   = busy_q;
   assign cfg_err    = err_q;
   assign stb_valid  = chain_stb && in_run_q;

`ifdef DEC_CTRL_STATS_EN
   logic [15:0] reconfig_cnt_q;
   logic [15:0] drop_cnt_q;

   // Reconfiguration count wraps; dropped start-up strobe count saturates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reconfig_cnt_q <= 16'd0;
         drop_cnt_q     <= 16'd0;
      end else begin
         if (state_q == StLoad) begin
            reconfig_cnt_q <= reconfig_cnt_q + 16'd1;
         end
         if ((state_q == StSettle) && chain_stb && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign reconfig_count = reconfig_cnt_q;
   assign drop_count     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dec_chain_ctrl.sv
// Bench for dec_chain_ctrl: directed table and sequences plus randomized traffic checked
// every cycle against a behavioural model of the chain controller.

module tb_dec_chain_ctrl;

   localparam int FLUSH  = 64;
   localparam int SETTLE = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       cfg_stb = 1'b0;
   logic [7:0] cfg_rate = 8'd0;
   logic       chain_stb = 1'b0;
   logic       run_o, hb1_bypass, hb2_bypass, cfg_busy, cfg_err, stb_valid;
   logic [7:0] cic_rate;
`ifdef DEC_CTRL_STATS_EN
   logic [15:0] reconfig_count, drop_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   dec_chain_ctrl #(
      .FLUSH_CYCLES   (FLUSH),
      .SETTLE_OUTPUTS (SETTLE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .cfg_stb    (cfg_stb),
      .cfg_rate   (cfg_rate),
      .chain_stb  (chain_stb),
      .run_o      (run_o),
      .cic_rate   (cic_rate),
      .hb1_bypass (hb1_bypass),
      .hb2_bypass (hb2_bypass),
      .cfg_busy   (cfg_busy),
      .cfg_err    (cfg_err),
      .stb_valid  (stb_valid)
`ifdef DEC_CTRL_STATS_EN
      ,
      .reconfig_count (reconfig_count),
      .drop_count     (drop_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   localparam int MIdle = 0, MLoad = 1, MSettle = 2, MRun = 3, MDrain = 4;
   int m_mode = MIdle;
   int m_cnt  = 0;     // strobes seen (settle) or drain cycles left (drain)
   bit m_reload = 0;
   int m_pcic = 1;
   bit m_ph1 = 1, m_ph2 = 1;
   int m_cic = 1;
   bit m_h1 = 1, m_h2 = 1;
   bit m_err = 0;

   always @(posedge clk) begin : model
      int r;
      bit acc;
      r = int'(cfg_rate);
      if (!rst_n) begin
         m_mode = MIdle; m_cnt = 0; m_reload = 0;
         m_pcic = 1; m_ph1 = 1; m_ph2 = 1;
         m_cic = 1; m_h1 = 1; m_h2 = 1; m_err = 0;
      end else begin
         acc = cfg_stb && (m_mode == MIdle || m_mode == MRun) && r != 0;
         if (acc) begin
            m_err = 0;
            if (r % 4 == 0) begin m_pcic = r / 4; m_ph1 = 0; m_ph2 = 0; end
            else if (r % 2 == 0) begin m_pcic = r / 2; m_ph1 = 1; m_ph2 = 0; end
            else begin m_pcic = r; m_ph1 = 1; m_ph2 = 1; end
         end else if (cfg_stb) begin
            m_err = 1;
         end
         case (m_mode)
            MIdle: begin
               if (acc) m_mode = MLoad;
               else if (enable) begin m_mode = MSettle; m_cnt = 0; end
            end
            MLoad: begin
               m_cic = m_pcic; m_h1 = m_ph1; m_h2 = m_ph2; m_reload = 0;
               if (enable) begin m_mode = MSettle; m_cnt = 0; end
               else m_mode = MIdle;
            end
            MSettle: begin
               if (!enable) begin m_mode = MDrain; m_cnt = FLUSH - 1; m_reload = 0; end
               else if (m_cnt == SETTLE) m_mode = MRun;
               else if (chain_stb) m_cnt = m_cnt + 1;
            end
            MRun: begin
               if (acc) begin m_mode = MDrain; m_cnt = FLUSH - 1; m_reload = 1; end
               else if (!enable) begin m_mode = MDrain; m_cnt = FLUSH - 1; m_reload = 0; end
            end
            default: begin
               if (m_cnt == 0) m_mode = m_reload ? MLoad : MIdle;
               else m_cnt = m_cnt - 1;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("model run_o", run_o, (m_mode == MSettle || m_mode == MRun));
         check("model cic_rate", cic_rate, m_cic);
         check("model hb1_bypass", hb1_bypass, m_h1);
         check("model hb2_bypass", hb2_bypass, m_h2);
         check("model cfg_busy", cfg_busy,
               (m_mode == MDrain || m_mode == MLoad || m_mode == MSettle));
         check("model cfg_err", cfg_err, m_err);
         check("model stb_valid", stb_valid, chain_stb && m_mode == MRun);
      end
   end

   // Strobe every 4 clocks from SETTLE entry; the first SETTLE strobes must be hidden.
   task automatic strobe_train(input int total);
      for (int k = 0; k < total; k++) begin
         chain_stb = 1'b1;
         #1;
         check($sformatf("gate stb_valid #%0d", k), stb_valid, (k >= SETTLE));
         step();
         chain_stb = 1'b0;
         if (k == SETTLE - 1) check("busy before run", cfg_busy, 1'b1);
         step();
         if (k == SETTLE - 1) begin
            check("busy falls in run", cfg_busy, 1'b0);
            check("run_o in run", run_o, 1'b1);
         end
         step();
         step();
      end
   endtask

   typedef struct {
      logic [7:0] rate;
      logic [7:0] cic;
      logic       hb1;
      logic       hb2;
   } dec_vec_t;

   dec_vec_t vecs[10];

   initial begin
      int n;
      vecs[0] = '{8'd8,   8'd2,   1'b0, 1'b0};
      vecs[1] = '{8'd6,   8'd3,   1'b1, 1'b0};
      vecs[2] = '{8'd5,   8'd5,   1'b1, 1'b1};
      vecs[3] = '{8'd1,   8'd1,   1'b1, 1'b1};
      vecs[4] = '{8'd2,   8'd1,   1'b1, 1'b0};
      vecs[5] = '{8'd4,   8'd1,   1'b0, 1'b0};
      vecs[6] = '{8'd255, 8'd255, 1'b1, 1'b1};
      vecs[7] = '{8'd254, 8'd127, 1'b1, 1'b0};
      vecs[8] = '{8'd252, 8'd63,  1'b0, 1'b0};
      vecs[9] = '{8'd12,  8'd3,   1'b0, 1'b0};

      // Reset, with a strobe present to show it is not qualified
      rst_n = 1'b0;
      chain_stb = 1'b1;
      step(); step(); step();
      chk_on = 1'b1;
      check("rst run_o", run_o, 1'b0);
      check("rst cic_rate", cic_rate, 8'd1);
      check("rst hb1_bypass", hb1_bypass, 1'b1);
      check("rst hb2_bypass", hb2_bypass, 1'b1);
      check("rst cfg_busy", cfg_busy, 1'b0);
      check("rst cfg_err", cfg_err, 1'b0);
      check("rst stb_valid", stb_valid, 1'b0);
      chain_stb = 1'b0;
      rst_n = 1'b1;
      step();

      // Rate decode from IDLE, new settings visible two cycles after the strobe
      for (int i = 0; i < 10; i++) begin
         cfg_stb = 1'b1;
         cfg_rate = vecs[i].rate;
         step();
         cfg_stb = 1'b0;
         check($sformatf("dec busy in load R=%0d", vecs[i].rate), cfg_busy, 1'b1);
         step();
         check($sformatf("dec cic R=%0d", vecs[i].rate), cic_rate, vecs[i].cic);
         check($sformatf("dec hb1 R=%0d", vecs[i].rate), hb1_bypass, vecs[i].hb1);
         check($sformatf("dec hb2 R=%0d", vecs[i].rate), hb2_bypass, vecs[i].hb2);
         check($sformatf("dec idle busy R=%0d", vecs[i].rate), cfg_busy, 1'b0);
      end

      // Start-up gating
      enable = 1'b1;
      step();
      check("settle run_o", run_o, 1'b1);
      check("settle busy", cfg_busy, 1'b1);
      strobe_train(7);

      // Reconfiguration while running: DRAIN (64) plus the LOAD cycle keep run_o low
      cfg_stb = 1'b1;
      cfg_rate = 8'd16;
      step();
      cfg_stb = 1'b0;
      check("drain old cic", cic_rate, 8'd3);
      n = 0;
      while (!run_o && n < 200) begin
         n++;
         step();
      end
      check("reconfig run_o low cycles", n[15:0], 16'(FLUSH + 1));
      check("reconfig cic", cic_rate, 8'd4);
      check("reconfig hb1", hb1_bypass, 1'b0);
      check("reconfig hb2", hb2_bypass, 1'b0);
      check("reconfig busy", cfg_busy, 1'b1);
      strobe_train(6);

      // Rejects: R=0 in RUN, then a strobe during DRAIN
      cfg_stb = 1'b1;
      cfg_rate = 8'd0;
      step();
      cfg_stb = 1'b0;
      check("rej0 err", cfg_err, 1'b1);
      check("rej0 still run", run_o, 1'b1);
      check("rej0 busy", cfg_busy, 1'b0);
      enable = 1'b0;
      step();
      cfg_stb = 1'b1;
      cfg_rate = 8'd10;
      step();
      cfg_stb = 1'b0;
      check("rej busy err", cfg_err, 1'b1);
      check("rej busy cic", cic_rate, 8'd4);
      n = 0;
      while (cfg_busy && n < 200) begin
         n++;
         step();
      end
      check("rej drain ends", cfg_busy, 1'b0);
      check("rej settings kept", cic_rate, 8'd4);
      cfg_stb = 1'b1;
      cfg_rate = 8'd4;
      step();
      cfg_stb = 1'b0;
      check("accept clears err", cfg_err, 1'b0);
      step();
      check("accept R=4 cic", cic_rate, 8'd1);
      check("accept R=4 hb1", hb1_bypass, 1'b0);
      check("accept R=4 hb2", hb2_bypass, 1'b0);

      // Abort in SETTLE after two strobes
      enable = 1'b1;
      step();
      chain_stb = 1'b1;
      step();
      chain_stb = 1'b0;
      step();
      chain_stb = 1'b1;
      step();
      chain_stb = 1'b0;
      enable = 1'b0;
      step();
      check("abort run_o", run_o, 1'b0);
      n = 0;
      while (cfg_busy && n < 200) begin
         n++;
         step();
      end
      check("abort drain cycles", n[15:0], 16'(FLUSH));
      check("abort cic kept", cic_rate, 8'd1);
      check("abort hb1 kept", hb1_bypass, 1'b0);

      // Reset in the middle of DRAIN, with cfg_err set beforehand
      enable = 1'b1;
      step();
      enable = 1'b0;
      step();
      cfg_stb = 1'b1;
      cfg_rate = 8'd3;
      step();
      cfg_stb = 1'b0;
      check("mid drain err", cfg_err, 1'b1);
      step(); step(); step();
      rst_n = 1'b0;
      step();
      check("mid rst run_o", run_o, 1'b0);
      check("mid rst cic", cic_rate, 8'd1);
      check("mid rst hb1", hb1_bypass, 1'b1);
      check("mid rst hb2", hb2_bypass, 1'b1);
      check("mid rst busy", cfg_busy, 1'b0);
      check("mid rst err", cfg_err, 1'b0);
      rst_n = 1'b1;
      step();

      // Randomized traffic against the model
      for (int i = 0; i < 6000; i++) begin
         rst_n = ($urandom_range(0, 799) != 0);
         if ($urandom_range(0, 29) == 0) enable = ~enable;
         cfg_stb = ($urandom_range(0, 19) == 0);
         cfg_rate = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         chain_stb = ($urandom_range(0, 2) == 0);
         step();
      end

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
